lcd_blit_engine: RTL and testbench

Parametrised sprite blitter for the LCD path. It pops 3-word blit descriptors from the command FIFO and fetches 16-bit pixels over an AHB-Lite read master. It then pushes LCD command/data words into the LCD write FIFO. Two modes are supported:
- Window mode: one window set per sprite, then a continuous pixel stream.
- Keyed mode: per-pixel addressing with transparent-colour skipping.

LCD init sequencing stays outside this block; the top-level mux selects between init and blit traffic.

---
 rtl/lcd_blit_engine.sv | 173 +++++++++++++++++
 tb/tb_lcd_blit_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_blit_engine.sv
// Sprite blitter: pops 3-word descriptors, fetches pixels over AHB-Lite,
// and pushes LCD window/command/data words into the LCD write FIFO.
module lcd_blit_engine #(
  parameter int          DIM_W     = 8,
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rempty,
  input  logic [31:0] rdata,
  output logic        rinc,
  input  logic        wfull,
  output logic        winc,
  output logic [16:0] wdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_LD2,
    S_HDR, S_FA, S_FD, S_PX, S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      x0, y0;
  logic             keyed;
  logic [DIM_W-1:0] wend, hend;
  logic [DIM_W-1:0] col, row;
  logic [31:0]      addr;
  logic [15:0]      pix;
  logic [3:0]       hidx;

  logic        ld;
  logic        emit;
  logic        last;
  logic        skip;
  logic        adv;
  logic [15:0] sel;
  logic [15:0] cx, cy;
  logic [15:0] xs, xe, ys, ye;
  logic [16:0] hword;

  assign ld   = (state == S_LD0) || (state == S_LD1) ||
                (state == S_LD2);
  assign emit = (state == S_HDR) || (state == S_PX);

  assign rinc   = ld & !rempty;
  assign winc   = emit & !wfull;
  assign HTRANS = (state == S_FA) ? 2'b10 : 2'b00;
  assign HADDR  = addr;
  assign HWRITE = 1'b0;
  assign done   = (state == S_DONE);
  assign busy   = ((state != S_IDLE) && (state != S_LD0)) ||
                  ((state == S_LD0) && !rempty);

  assign sel  = addr[1] ? HRDATA[31:16] : HRDATA[15:0];
  assign last = (col == wend) && (row == hend);
  assign skip = keyed && (sel == KEY_COLOR);
  assign adv  = ((state == S_PX) && !wfull) ||
                ((state == S_FD) && HREADY && skip);

  // Keyed mode draws a 1x1 window at the current pixel
  assign cx = x0 + 16'(col);
  assign cy = y0 + 16'(row);
  assign xs = keyed ? cx : x0;
  assign ys = keyed ? cy : y0;
  assign xe = keyed ? cx : x0 + 16'(wend);
  assign ye = keyed ? cy : y0 + 16'(hend);

  always_comb begin
    hword = {1'b0, 16'h002C};
    case (hidx)
      4'd0:    hword = {1'b0, 16'h002A};
      4'd1:    hword = {1'b1, 8'h00, xs[15:8]};
      4'd2:    hword = {1'b1, 8'h00, xs[7:0]};
      4'd3:    hword = {1'b1, 8'h00, xe[15:8]};
      4'd4:    hword = {1'b1, 8'h00, xe[7:0]};
      4'd5:    hword = {1'b0, 16'h002B};
      4'd6:    hword = {1'b1, 8'h00, ys[15:8]};
      4'd7:    hword = {1'b1, 8'h00, ys[7:0]};
      4'd8:    hword = {1'b1, 8'h00, ye[15:8]};
      4'd9:    hword = {1'b1, 8'h00, ye[7:0]};
      default: hword = {1'b0, 16'h002C};
    endcase
  end

  always_comb begin
    wdata = '0;
    if (state == S_HDR)
      wdata = hword;
    else if (state == S_PX)
      wdata = {1'b1, pix};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x0    <= '0;
      y0    <= '0;
      keyed <= 1'b0;
      wend  <= '0;
      hend  <= '0;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
      pix   <= '0;
      hidx  <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LD0;
        S_LD0: if (!rempty) begin
          x0    <= rdata[31:16];
          y0    <= rdata[15:0];
          state <= S_LD1;
        end
        S_LD1: if (!rempty) begin
          keyed <= rdata[31];
          wend  <= rdata[16 +: DIM_W];
          hend  <= rdata[DIM_W-1:0];
          state <= S_LD2;
        end
        S_LD2: if (!rempty) begin
          addr  <= rdata;
          col   <= '0;
          row   <= '0;
          hidx  <= '0;
          state <= keyed ? S_FA : S_HDR;
        end
        S_HDR: if (!wfull) begin
          if (hidx == 4'd10) begin
            hidx  <= '0;
            state <= keyed ? S_PX : S_FA;
          end else begin
            hidx <= hidx + 4'd1;
          end
        end
        S_FA: if (HREADY) state <= S_FD;
        S_FD: if (HREADY) begin
          pix <= sel;
          if (skip)
            state <= last ? S_DONE : S_FA;
          else
            state <= keyed ? S_HDR : S_PX;
        end
        S_PX: if (!wfull) state <= last ? S_DONE : S_FA;
        S_DONE: begin
          col   <= '0;
          row   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Pixel advance; counters freeze on the last pixel
      if (adv) begin
        addr <= addr + 32'd2;
        if (!last) begin
          if (col == wend) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_blit_engine.sv
// Scoreboard bench for lcd_blit_engine: FIFO/AHB models feed the DUT,
// monitors pop expected LCD words and AHB addresses and compare.
module tb_lcd_blit_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rempty = 1'b1;
  logic [31:0] rdata = '0;
  logic        rinc;
  logic        wfull = 1'b0;
  logic        winc;
  logic [16:0] wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  lcd_blit_engine #(.DIM_W(8), .KEY_COLOR(16'hF81F)) dut (
    .clk(clk), .rst_n(rst_n),
    .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .wfull(wfull), .winc(winc), .wdata(wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRDATA(HRDATA),
    .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] cmd_q[$];
  logic [15:0] mem[int];
  bit hold = 1'b0;
  bit bp = 1'b0;
  int stall_n = 0;
  int done_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rd16(logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'hF81F;
  endfunction

  function automatic logic [31:0] word(logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h3;
    return {rd16(b + 32'd2), rd16(b)};
  endfunction

  task automatic send(logic [15:0] x, logic [15:0] y, bit k,
                      int w, int h, logic [31:0] base);
    cmd_q.push_back({x, y});
    cmd_q.push_back({k, 7'b0, 8'(w - 1), 8'b0, 8'(h - 1)});
    cmd_q.push_back(base);
  endtask

  task automatic exp_hdr(logic [15:0] xs, logic [15:0] xe,
                         logic [15:0] ys, logic [15:0] ye);
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 8'h00, xs[15:8]});
    exp_q.push_back({1'b1, 8'h00, xs[7:0]});
    exp_q.push_back({1'b1, 8'h00, xe[15:8]});
    exp_q.push_back({1'b1, 8'h00, xe[7:0]});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 8'h00, ys[15:8]});
    exp_q.push_back({1'b1, 8'h00, ys[7:0]});
    exp_q.push_back({1'b1, 8'h00, ye[15:8]});
    exp_q.push_back({1'b1, 8'h00, ye[7:0]});
    exp_q.push_back({1'b0, 16'h002C});
  endtask

  task automatic wait_done(string name);
    int t;
    int start;
    t = 0;
    start = done_cnt;
    while (done_cnt == start && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check({name, "_done"}, 32'(done_cnt - start), 32'd1);
    check({name, "_lcd_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_ahb_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  // Command FIFO model (show-ahead)
  initial forever begin
    bit pop;
    @(negedge clk);
    pop = rinc;
    @(posedge clk);
    #1;
    if (pop && cmd_q.size() > 0) cmd_q.delete(0);
    rempty = hold || (cmd_q.size() == 0);
    rdata = (cmd_q.size() > 0) ? cmd_q[0] : 32'h0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp) wfull = ~wfull;
  end

  // LCD monitor
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (winc) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL lcd_push: got %h required none", wdata);
      end else begin
        check("lcd_push", 32'(wdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // AHB slave with optional data-phase wait states
  initial forever begin
    logic [31:0] a;
    @(negedge clk);
    if (HTRANS == 2'b10 && HREADY) begin
      a = HADDR;
      if (addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ahb_addr: got %h required none", a);
      end else begin
        check("ahb_addr", a, addr_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (stall_n > 0) begin
        HREADY = 1'b0;
        HRDATA = 32'hDEADDEAD;
        repeat (stall_n) begin
          @(negedge clk);
          check("htrans_stall", 32'(HTRANS), 32'd0);
          @(posedge clk);
          #1;
        end
        stall_n = 0;
      end
      HREADY = 1'b1;
      HRDATA = word(a);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [16:0] t1 [15] = '{
    17'h0002A, 17'h10000, 17'h10010, 17'h10000, 17'h10011,
    17'h0002B, 17'h10000, 17'h10020, 17'h10000, 17'h10021,
    17'h0002C, 17'h1000A, 17'h1000B, 17'h1000C, 17'h1000D};
  logic [16:0] t2 [12] = '{
    17'h0002A, 17'h10000, 17'h10006, 17'h10000, 17'h10006,
    17'h0002B, 17'h10000, 17'h10007, 17'h10000, 17'h10007,
    17'h0002C, 17'h11234};

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Window 2x2
    mem[32'h1000] = 16'h000A;
    mem[32'h1002] = 16'h000B;
    mem[32'h1004] = 16'h000C;
    mem[32'h1006] = 16'h000D;
    foreach (t1[i]) exp_q.push_back(t1[i]);
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h1000 + 32'(2 * i));
    send(16'h0010, 16'h0020, 1'b0, 2, 2, 32'h1000);
    wait_done("win2x2");

    // Keyed 3x1
    mem[32'h2000] = 16'hF81F;
    mem[32'h2002] = 16'h1234;
    mem[32'h2004] = 16'hF81F;
    foreach (t2[i]) exp_q.push_back(t2[i]);
    for (int i = 0; i < 3; i++) addr_q.push_back(32'h2000 + 32'(2 * i));
    send(16'h0005, 16'h0007, 1'b1, 3, 1, 32'h2000);
    wait_done("keyed3x1");

    // Backpressure: same sprite as the first run
    @(posedge clk);
    #1;
    bp = 1'b1;
    foreach (t1[i]) exp_q.push_back(t1[i]);
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h1000 + 32'(2 * i));
    send(16'h0010, 16'h0020, 1'b0, 2, 2, 32'h1000);
    wait_done("backpressure");
    @(posedge clk);
    #1;
    bp = 1'b0;
    wfull = 1'b0;

    // HREADY low for 4 data-phase cycles
    mem[32'h3002] = 16'h5A5A;
    stall_n = 4;
    exp_hdr(16'h0100, 16'h0100, 16'h0200, 16'h0200);
    exp_q.push_back(17'h15A5A);
    addr_q.push_back(32'h3002);
    send(16'h0100, 16'h0200, 1'b0, 1, 1, 32'h3002);
    wait_done("hready_stall");

    // Command FIFO runs dry before w2; XE wraps mod 2^16
    mem[32'h4000] = 16'h1111;
    mem[32'h4002] = 16'h2222;
    exp_hdr(16'hFFFF, 16'h0000, 16'h0001, 16'h0001);
    exp_q.push_back(17'h11111);
    exp_q.push_back(17'h12222);
    addr_q.push_back(32'h4000);
    addr_q.push_back(32'h4002);
    cmd_q.push_back({16'hFFFF, 16'h0001});
    cmd_q.push_back({1'b0, 7'b0, 8'd1, 8'b0, 8'd0});
    t = 0;
    while (cmd_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("ld2_reached", 32'(cmd_q.size()), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("ld2_stall", {28'b0, rinc, HTRANS, winc, busy}, 32'd1);
    end
    cmd_q.push_back(32'h4000);
    wait_done("rempty_gap");

    // Reset during a PX stall
    mem[32'h5000] = 16'h7777;
    exp_hdr(16'h0008, 16'h0008, 16'h0009, 16'h0009);
    exp_q.push_back(17'h17777);
    addr_q.push_back(32'h5000);
    send(16'h0008, 16'h0009, 1'b0, 1, 1, 32'h5000);
    t = 0;
    while (exp_q.size() != 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    wfull = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    wfull = 1'b0;
    #1;
    check("abort_winc", 32'(winc), 32'd0);
    check("abort_htrans", 32'(HTRANS), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    addr_q.delete();
    cmd_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem[32'h6000] = 16'h4321;
    exp_hdr(16'h0030, 16'h0030, 16'h0040, 16'h0040);
    exp_q.push_back(17'h14321);
    addr_q.push_back(32'h6000);
    send(16'h0030, 16'h0040, 1'b0, 1, 1, 32'h6000);
    wait_done("after_reset");

    // Full-width keyed 256x2, only the very last pixel opaque
    mem[32'h83FE] = 16'h0F0F;
    exp_hdr(16'h10FF, 16'h10FF, 16'h0001, 16'h0001);
    exp_q.push_back(17'h10F0F);
    for (int i = 0; i < 512; i++) addr_q.push_back(32'h8000 + 32'(2 * i));
    send(16'h1000, 16'h0000, 1'b1, 256, 2, 32'h8000);
    wait_done("full_width");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
